// File: rtl/reg_scan_stepper.sv
// Tick-driven scanner that reads the register file's debug port one address per
// trigger and latches each value onto the display outputs.
module reg_scan_stepper #(
  parameter int NUM_REGS   = 16,
  parameter int ADDR_W     = 4,
  parameter int DATA_W     = 8,
  parameter int RD_TIMEOUT = 15
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_tick,
  input  logic              i_run_en,
  input  logic              i_step,
  output logic              o_rd_req,
  output logic [ADDR_W-1:0] o_rd_addr,
  input  logic [DATA_W-1:0] i_rd_data,
  input  logic              i_rd_valid,
  output logic [ADDR_W-1:0] o_disp_addr,
  output logic [DATA_W-1:0] o_disp_data,
  output logic              o_disp_update,
  output logic              o_busy,
  output logic              o_timeout_err,
  output logic              o_overrun
);

  localparam int CNT_W = (RD_TIMEOUT > 1) ? $clog2(RD_TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0]  LAST_WAIT = CNT_W'(RD_TIMEOUT - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_REGS - 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, SHOW} state_t;

  state_t            r_state;
  state_t            w_nextState;
  logic              r_tickQ;
  logic              r_stepQ;
  logic              r_pending;
  logic              r_overrun;
  logic              r_timeoutErr;
  logic [CNT_W-1:0]  r_waitCnt;
  logic [ADDR_W-1:0] r_curAddr;
  logic [ADDR_W-1:0] r_dispAddr;
  logic [DATA_W-1:0] r_dispData;
  logic [DATA_W-1:0] r_capData;
  logic              w_trig;
  logic              w_capture;
  logic              w_timeout;

  // Simultaneous tick and step edges collapse into a single trigger.
  assign w_trig = (i_tick & ~r_tickQ & i_run_en) | (i_step & ~r_stepQ);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= IDLE;
    else          r_state <= w_nextState;
  end

  always_comb begin
    w_nextState   = r_state;
    o_rd_req      = 1'b0;
    o_disp_update = 1'b0;
    w_capture     = 1'b0;
    w_timeout     = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_trig || r_pending) w_nextState = REQ;
      end
      REQ: begin
        o_rd_req = 1'b1;
        if (i_rd_valid) begin
          w_capture   = 1'b1;
          w_nextState = SHOW;
        end else begin
          w_nextState = WAIT;
        end
      end
      WAIT: begin
        if (i_rd_valid) begin
          w_capture   = 1'b1;
          w_nextState = SHOW;
        end else if (r_waitCnt == LAST_WAIT) begin
          w_timeout   = 1'b1;
          w_nextState = SHOW;
        end
      end
      SHOW: begin
        o_disp_update = 1'b1;
        w_nextState   = IDLE;
      end
      default: w_nextState = IDLE;
    endcase
  end

  // A trigger arriving while IDLE already services a pending one stays queued.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_tickQ      <= 1'b0;
      r_stepQ      <= 1'b0;
      r_pending    <= 1'b0;
      r_overrun    <= 1'b0;
      r_timeoutErr <= 1'b0;
      r_waitCnt    <= '0;
      r_curAddr    <= '0;
      r_dispAddr   <= '0;
      r_dispData   <= '0;
      r_capData    <= '0;
    end else begin
      r_tickQ <= i_tick;
      r_stepQ <= i_step;
      if (r_state == IDLE) begin
        r_pending <= r_pending & w_trig;
      end else if (w_trig) begin
        if (!r_pending) r_pending <= 1'b1;
        else            r_overrun <= 1'b1;
      end
      if (r_state == REQ)       r_waitCnt <= '0;
      else if (r_state == WAIT) r_waitCnt <= r_waitCnt + 1'b1;
      if (w_capture) r_capData <= i_rd_data;
      if (w_timeout) begin
        r_capData    <= '1;
        r_timeoutErr <= 1'b1;
      end
      if (r_state == SHOW) begin
        r_dispAddr <= r_curAddr;
        r_dispData <= r_capData;
        r_curAddr  <= (r_curAddr == LAST_ADDR) ? '0 : r_curAddr + 1'b1;
      end
    end
  end

  assign o_rd_addr     = r_curAddr;
  assign o_disp_addr   = r_dispAddr;
  assign o_disp_data   = r_dispData;
  assign o_busy        = (r_state != IDLE);
  assign o_timeout_err = r_timeoutErr;
  assign o_overrun     = r_overrun;

endmodule

// File: tb/tb_reg_scan_stepper.sv
// Scoreboard bench for reg_scan_stepper: a register-file model answers reads with
// addr+0x10 after a programmable latency; expected display values are queued per read.
module tb_reg_scan_stepper;

  localparam int NUM_REGS   = 16;
  localparam int ADDR_W     = 4;
  localparam int DATA_W     = 8;
  localparam int RD_TIMEOUT = 15;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              tick = 1'b0;
  logic              run_en = 1'b0;
  logic              step = 1'b0;
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data = '0;
  logic              rd_valid = 1'b0;
  logic [ADDR_W-1:0] disp_addr;
  logic [DATA_W-1:0] disp_data;
  logic              disp_update;
  logic              busy;
  logic              timeout_err;
  logic              overrun;

  reg_scan_stepper #(
    .NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_TIMEOUT(RD_TIMEOUT)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_tick(tick), .i_run_en(run_en), .i_step(step),
    .o_rd_req(rd_req), .o_rd_addr(rd_addr), .i_rd_data(rd_data), .i_rd_valid(rd_valid),
    .o_disp_addr(disp_addr), .o_disp_data(disp_data), .o_disp_update(disp_update),
    .o_busy(busy), .o_timeout_err(timeout_err), .o_overrun(overrun)
  );

  always #5 clk = ~clk;

  int testCount = 0;
  int failCount = 0;
  int modelLat = 1;
  int modelCnt = 0;
  logic [DATA_W-1:0] modelData = '0;
  int reqCount = 0;
  int updCount = 0;
  int sinceReq = 0;
  int sinceShow = 0;
  int lastReqToShow = 0;
  int lastShowToReq = 0;
  bit cmpNext = 1'b0;
  logic [ADDR_W-1:0] expAddr = '0;
  logic [ADDR_W+DATA_W-1:0] sbQ[$];

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Register-file model: answers modelLat cycles after rd_req; modelLat=0 never answers.
  always @(negedge clk) begin
    if (!rst_n) begin
      modelCnt = 0;
      rd_valid = 1'b0;
    end else begin
      rd_valid = 1'b0;
      if (modelCnt > 0) begin
        modelCnt--;
        if (modelCnt == 0) begin
          rd_valid = 1'b1;
          rd_data  = modelData;
        end
      end
      if (rd_req && modelLat > 0) begin
        modelCnt  = modelLat;
        modelData = DATA_W'(rd_addr) + 8'h10;
      end
    end
  end

  // Monitor: pushes expectations on each read, pops and compares after each display update.
  always @(negedge clk) begin
    if (!rst_n) begin
      cmpNext = 1'b0;
    end else begin
      logic [ADDR_W+DATA_W-1:0] e;
      sinceReq++;
      sinceShow++;
      if (cmpNext) begin
        cmpNext = 1'b0;
        if (sbQ.size() == 0) begin
          checkOutput("sbUnderflow", 32'd0, 32'd1);
        end else begin
          e = sbQ.pop_front();
          checkOutput("dispAddr", 32'(disp_addr), 32'(e[ADDR_W+DATA_W-1:DATA_W]));
          checkOutput("dispData", 32'(disp_data), 32'(e[DATA_W-1:0]));
        end
      end
      if (rd_req) begin
        reqCount++;
        checkOutput("rdAddr", 32'(rd_addr), 32'(expAddr));
        sbQ.push_back({expAddr, (modelLat == 0) ? 8'hFF : (DATA_W'(expAddr) + 8'h10)});
        expAddr = (expAddr == ADDR_W'(NUM_REGS - 1)) ? '0 : expAddr + 1'b1;
        lastShowToReq = sinceShow;
        sinceReq = 0;
      end
      if (disp_update) begin
        updCount++;
        lastReqToShow = sinceReq;
        sinceShow = 0;
        cmpNext = 1'b1;
      end
    end
  end

  task automatic clearModel();
    sbQ.delete();
    expAddr  = '0;
    reqCount = 0;
    updCount = 0;
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    tick  = 1'b0;
    step  = 1'b0;
    repeat (3) @(posedge clk);
    clearModel();
    #1 rst_n = 1'b1;
  endtask

  task automatic applyStimulus(input bit doTick, input bit doStep, input int width);
    @(posedge clk);
    #1;
    tick = doTick;
    step = doStep;
    repeat (width) @(posedge clk);
    #1;
    tick = 1'b0;
    step = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic waitUpdates(input int target, input int budget);
    for (int i = 0; i < budget && updCount < target; i++) @(posedge clk);
    if (updCount < target) checkOutput("waitUpd", 32'(updCount), 32'(target));
    repeat (3) @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int base;
    int updBase;

    doReset();
    @(negedge clk);
    checkOutput("rstDispAddr", 32'(disp_addr), 32'd0);
    checkOutput("rstDispData", 32'(disp_data), 32'd0);
    checkOutput("rstRdReq", 32'(rd_req), 32'd0);
    checkOutput("rstRdAddr", 32'(rd_addr), 32'd0);
    checkOutput("rstBusy", 32'(busy), 32'd0);
    checkOutput("rstUpdate", 32'(disp_update), 32'd0);
    checkOutput("rstTimeout", 32'(timeout_err), 32'd0);
    checkOutput("rstOverrun", 32'(overrun), 32'd0);

    // Three 2-cycle ticks, 1-cycle latency; first one also checks trigger-to-REQ latency.
    run_en   = 1'b1;
    modelLat = 1;
    @(posedge clk);
    #1 tick = 1'b1;
    @(negedge clk);
    checkOutput("reqEarly", 32'(rd_req), 32'd0);
    @(negedge clk);
    checkOutput("reqLatency", 32'(rd_req), 32'd1);
    @(posedge clk);
    #1 tick = 1'b0;
    waitUpdates(1, 30);
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b1, 1'b0, 2);
      waitUpdates(2 + i, 30);
    end
    checkOutput("t1Reads", 32'(reqCount), 32'd3);
    checkOutput("t1Updates", 32'(updCount), 32'd3);
    checkOutput("t1LastData", 32'(disp_data), 32'h12);
    checkOutput("t1Busy", 32'(busy), 32'd0);

    // Fourteen more triggers: 17 total, address wraps 15 -> 0.
    for (int i = 0; i < 14; i++) begin
      applyStimulus(1'b1, 1'b0, 2);
      waitUpdates(4 + i, 30);
    end
    checkOutput("wrapReads", 32'(reqCount), 32'd17);
    checkOutput("wrapAddr", 32'(disp_addr), 32'd0);
    checkOutput("wrapData", 32'(disp_data), 32'h10);

    // Ticks ignored with run_en low; step honoured; simultaneous edges give one read.
    base   = reqCount;
    run_en = 1'b0;
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 2);
    repeat (5) @(posedge clk);
    checkOutput("runOffReads", 32'(reqCount - base), 32'd0);
    updBase = updCount;
    applyStimulus(1'b0, 1'b1, 1);
    waitUpdates(updBase + 1, 30);
    checkOutput("stepReads", 32'(reqCount - base), 32'd1);
    run_en  = 1'b1;
    updBase = updCount;
    applyStimulus(1'b1, 1'b1, 2);
    waitUpdates(updBase + 1, 30);
    repeat (10) @(posedge clk);
    checkOutput("bothReads", 32'(reqCount - base), 32'd2);
    checkOutput("bothAddr", 32'(disp_addr), 32'd2);

    // No response: timeout shows 0xFF, sets sticky flag, address still advances.
    modelLat = 0;
    updBase  = updCount;
    applyStimulus(1'b1, 1'b0, 2);
    waitUpdates(updBase + 1, 40);
    checkOutput("toFlag", 32'(timeout_err), 32'd1);
    checkOutput("toLatency", 32'(lastReqToShow), 32'(RD_TIMEOUT + 1));
    checkOutput("toData", 32'(disp_data), 32'hFF);
    modelLat = 1;
    updBase  = updCount;
    applyStimulus(1'b1, 1'b0, 2);
    waitUpdates(updBase + 1, 30);
    checkOutput("toNextAddr", 32'(disp_addr), 32'd4);
    checkOutput("toSticky", 32'(timeout_err), 32'd1);

    // Slow reads: second trigger queued, third dropped with overrun.
    checkOutput("ovrBefore", 32'(overrun), 32'd0);
    modelLat = 10;
    base     = reqCount;
    updBase  = updCount;
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 2);
    waitUpdates(updBase + 2, 80);
    repeat (20) @(posedge clk);
    @(negedge clk);
    checkOutput("ovrFlag", 32'(overrun), 32'd1);
    checkOutput("ovrReads", 32'(reqCount - base), 32'd2);
    checkOutput("ovrGap", 32'(lastShowToReq), 32'd2);
    checkOutput("ovrLatency", 32'(lastReqToShow), 32'd11);

    // Reset asserted in WAIT clears everything at once; next read starts at address 0.
    modelLat = 0;
    @(posedge clk);
    #1 tick = 1'b1;
    repeat (2) @(posedge clk);
    #1 tick = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    checkOutput("preRstBusy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("midRstBusy", 32'(busy), 32'd0);
    checkOutput("midRstRdReq", 32'(rd_req), 32'd0);
    checkOutput("midRstRdAddr", 32'(rd_addr), 32'd0);
    checkOutput("midRstDispAddr", 32'(disp_addr), 32'd0);
    checkOutput("midRstDispData", 32'(disp_data), 32'd0);
    checkOutput("midRstTimeout", 32'(timeout_err), 32'd0);
    checkOutput("midRstOverrun", 32'(overrun), 32'd0);
    repeat (2) @(posedge clk);
    clearModel();
    #1 rst_n = 1'b1;
    modelLat = 1;
    applyStimulus(1'b1, 1'b0, 2);
    waitUpdates(1, 30);
    checkOutput("postRstAddr", 32'(disp_addr), 32'd0);
    checkOutput("postRstData", 32'(disp_data), 32'h10);
    checkOutput("sbDrained", 32'(sbQ.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
